imem_fetch_unit: RTL and testbench
==================================

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction words stored (power of two, >=4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded at reset (word-aligned).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fetch_en  input  1  enables fetching.
REQ-007 SHALL have port stall  input  1  holds PC and all outputs.
REQ-008 SHALL have port flush  input  1  redirects PC to flush_pc.
REQ-009 SHALL have port flush_pc  input  32  redirect target.
REQ-010 SHALL have port load_en  input  1  program-load write strobe.
REQ-011 SHALL have port load_addr  input  32  byte address of load word.
REQ-012 SHALL have port load_data  input  32  load word.
REQ-013 SHALL have port pc_out  output  32  PC of instr_out.
REQ-014 SHALL have port instr_out  output  32  registered instruction.
REQ-015 SHALL have port instr_valid  output  1  instr_out/pc_out valid this cycle.
REQ-016 SHALL have port fault  output  1  sticky fetch fault (misaligned or out-of-range PC).

Function
REQ-017 SHALL implement states IDLE, FETCH, FAULT.
REQ-018 Transitions SHALL be: IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; FETCH->FAULT on a bad PC; FAULT->FETCH (fetch_en=1) or FAULT->IDLE (fetch_en=0) only on flush with a good flush_pc, or on reset.
REQ-019 A PC SHALL be bad when pc[1:0]!=0 or pc >= DEPTH*4.
REQ-020 In FETCH with stall=0, flush=0 and a good PC, the next edge SHALL register instr_out=mem[pc>>2], pc_out=pc, instr_valid=1, and advance pc<=pc+4 (one-cycle latency).
REQ-021 In FETCH with a bad PC, the next edge SHALL drive fault=1, instr_valid=0, instr_out=NOP_INSTR and hold pc.
REQ-022 stall=1 (and flush=0) SHALL hold pc, pc_out, instr_out, instr_valid and state unchanged.
REQ-023 flush=1 SHALL take priority over stall and fetch_en: next edge pc<=flush_pc, instr_valid=0, instr_out=NOP_INSTR, fault cleared; if flush_pc is bad, fault is set on the following fetch attempt.
REQ-024 In IDLE, instr_valid SHALL be 0 and pc SHALL hold.
REQ-025 load_en SHALL write mem[load_addr>>2]<=load_data only in IDLE or FAULT with load_addr good; otherwise the write is ignored.
REQ-026 A load and a fetch to the same word in the same cycle cannot occur, because loads are restricted to non-FETCH states.
REQ-027 A PC wrap from DEPTH*4-4 to DEPTH*4 SHALL be treated as out-of-range (fault), not wrapped to 0.
REQ-028 pc_out SHALL always equal the address instr_out was read from when instr_valid=1.

Reset
REQ-029 With reset=1 at an edge, the block SHALL set state=IDLE, pc=RESET_PC, pc_out=RESET_PC, instr_out=NOP_INSTR, instr_valid=0, fault=0; memory contents SHALL be retained.
REQ-030 reset SHALL override flush, stall and load_en, including mid-fetch and in FAULT.

Verification
REQ-031 Load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013 in IDLE, then hold fetch_en=1 -> pc_out 0,4,8,12 with those instr_out values and instr_valid=1, each one cycle after the PC is presented.
REQ-032 Assert stall for 3 cycles after pc_out=4 -> pc_out=4 and instr_out=32'h00A00113 held for 3 cycles; the sequence resumes at 8.
REQ-033 Assert flush with flush_pc=0 while stall=1 at pc_out=8 -> next cycle instr_valid=0 and instr_out=32'h00000013; the cycle after, pc_out=0 and instr_valid=1.
REQ-034 Assert flush with flush_pc=32'h6 -> fault=1 and instr_valid=0 within 2 cycles; a subsequent flush with flush_pc=0 clears fault and fetch resumes at 0.
REQ-035 Run to pc=DEPTH*4-4 -> last word valid; next cycle fault=1; apply reset -> all outputs at reset values and memory word 0 is still 32'h00500093.
REQ-036 Assert load_en in FETCH with load_addr=0 -> memory unchanged (verified by refetching address 0).

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a sequential fetch engine. Words are loaded while
// the engine is idle or faulted. Fetch produces one registered instruction
// per cycle, and the engine supports stall, flush/redirect and a sticky fault.
module imem_fetch_unit #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fault
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] PC_LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        ld_we;

  logic [31:0] mem_q [DEPTH];

  // A byte address is unusable if it is misaligned or runs past the last word.
  // Incrementing past the last word therefore faults instead of wrapping.
  function automatic logic pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || ({1'b0, p} >= PC_LIMIT);
  endfunction

  // Loads are accepted only outside FETCH, so a load and a read never collide.
  assign ld_we = load_en && !reset && (state_q != S_FETCH) && !pc_bad(load_addr);

  // Next-state and next-output logic. Flush takes priority over stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    if (flush) begin
      pc_d    = flush_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      // A faulted engine only leaves FAULT when it is redirected to a usable
      // PC. A bad target from FETCH is caught on the next fetch attempt.
      if (!(state_q == S_FAULT && pc_bad(flush_pc))) begin
        fault_d = 1'b0;
        state_d = fetch_en ? S_FETCH : S_IDLE;
      end
    end else if (!stall) begin
      case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          if (fetch_en) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!fetch_en) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else if (pc_bad(pc_q)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else begin
            instr_d  = mem_q[pc_q[AW+1:2]];
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
          end
        end
        S_FAULT: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs. Reset overrides every other control input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  // Program-load write port. Memory contents are kept through reset.
  always_ff @(posedge clk) begin
    if (ld_we) mem_q[load_addr[AW+1:2]] <= load_data;
  end

  assign pc_out      = pc_out_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit. It uses a small 16-word memory so the
// end-of-memory fault is reachable quickly.
module tb_imem_fetch_unit;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, fetch_en, stall, flush, load_en;
  logic [31:0] flush_pc, load_addr, load_data;
  logic [31:0] pc_out, instr_out;
  logic        instr_valid, fault;

  int total = 0;
  int bad   = 0;
  logic [31:0] words [DEPTH];

  imem_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall),
    .flush(flush), .flush_pc(flush_pc), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .pc_out(pc_out),
    .instr_out(instr_out), .instr_valid(instr_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic f);
    chk({tag, ".pc"},    pc_out,             pc);
    chk({tag, ".instr"}, instr_out,          ins);
    chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({tag, ".fault"}, {31'b0, fault},     {31'b0, f});
  endtask

  initial begin
    words[0] = 32'h00500093; words[1] = 32'h00A00113;
    words[2] = 32'h002081B3; words[3] = 32'h00000013;
    for (int i = 4; i < DEPTH; i++) words[i] = 32'hA000_0000 + i;

    reset = 1; fetch_en = 0; stall = 0; flush = 0; flush_pc = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    tick(); tick();
    chk_out("reset", 32'h0, NOP, 1'b0, 1'b0);
    reset = 0;

    // Program load in IDLE.
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1; load_addr = i * 4; load_data = words[i];
      tick();
    end
    load_en = 0;
    tick();
    chk_out("idle", 32'h0, NOP, 1'b0, 1'b0);

    // Sequential fetch: one cycle to enter FETCH, then one word per cycle.
    fetch_en = 1;
    tick();
    chk("enter.valid", {31'b0, instr_valid}, 32'h0);
    tick(); chk_out("f0", 32'h0, words[0], 1'b1, 1'b0);
    tick(); chk_out("f4", 32'h4, words[1], 1'b1, 1'b0);

    // Stall holds the outputs for 3 cycles.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stall", 32'h4, words[1], 1'b1, 1'b0);
    end
    stall = 0;
    tick(); chk_out("f8", 32'h8, words[2], 1'b1, 1'b0);

    // Flush during stall wins.
    stall = 1; flush = 1; flush_pc = 0;
    tick();
    chk("flush.valid", {31'b0, instr_valid}, 32'h0);
    chk("flush.instr", instr_out, NOP);
    stall = 0; flush = 0;
    tick(); chk_out("reflush0", 32'h0, words[0], 1'b1, 1'b0);
    tick(); chk_out("reflush4", 32'h4, words[1], 1'b1, 1'b0);

    // Misaligned redirect faults on the next fetch attempt.
    flush = 1; flush_pc = 32'h6;
    tick();
    chk("mis.valid0", {31'b0, instr_valid}, 32'h0);
    chk("mis.fault0", {31'b0, fault}, 32'h0);
    flush = 0;
    tick();
    chk("mis.fault1", {31'b0, fault}, 32'h1);
    chk("mis.valid1", {31'b0, instr_valid}, 32'h0);
    chk("mis.instr1", instr_out, NOP);
    tick();
    chk("mis.sticky", {31'b0, fault}, 32'h1);
    flush = 1; flush_pc = 0;
    tick();
    chk("clr.fault", {31'b0, fault}, 32'h0);
    flush = 0;
    tick(); chk_out("resume0", 32'h0, words[0], 1'b1, 1'b0);

    // A load attempted during FETCH must be dropped.
    load_en = 1; load_addr = 0; load_data = 32'hDEAD_BEEF;
    tick(); chk_out("ldfetch4", 32'h4, words[1], 1'b1, 1'b0);
    load_en = 0;
    flush = 1; flush_pc = 0;
    tick();
    flush = 0;
    tick(); chk_out("ldchk0", 32'h0, words[0], 1'b1, 1'b0);

    // Run to the last word, then fault past the end.
    for (int i = 1; i < DEPTH; i++) tick();
    chk_out("last", (DEPTH - 1) * 4, words[DEPTH-1], 1'b1, 1'b0);
    tick();
    chk("end.fault", {31'b0, fault}, 32'h1);
    chk("end.valid", {31'b0, instr_valid}, 32'h0);

    // Reset from FAULT while other controls are active; memory survives.
    reset = 1; stall = 1; flush = 1; flush_pc = 32'h8;
    load_en = 1; load_addr = 0; load_data = 32'h1234_5678;
    tick();
    chk_out("rst2", 32'h0, NOP, 1'b0, 1'b0);
    reset = 0; stall = 0; flush = 0; load_en = 0;
    tick();
    tick(); chk_out("post0", 32'h0, words[0], 1'b1, 1'b0);

    // Dropping fetch_en returns to IDLE, and the PC holds.
    fetch_en = 0;
    tick();
    chk("idle2.valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("idle2.valid2", {31'b0, instr_valid}, 32'h0);
    fetch_en = 1;
    tick(); tick();
    chk_out("idle2.resume", 32'h4, words[1], 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
